// File: rtl/jb_pkg.sv
// jb_pkg: shared arbiter state encoding and the out-of-range read default.
package jb_pkg;
  typedef enum logic [2:0] {IDLE, CPU, HS_RD, HS_CAP, HS_WR, HS_ACK, HS_HOLD} state_t;
  localparam logic [7:0] RD_OOR_DEF = 8'hFF;
endpackage

// File: rtl/hs_ram_arb_if.sv
// hs_ram_arb_if: CPU, hiscore and work-RAM signals of the arbiter; slave is the arbiter side.
interface hs_ram_arb_if #(parameter int AW = 11) ();
  logic          cpu_cs;
  logic          cpu_wr;
  logic [AW-1:0] cpu_ad;
  logic [7:0]    cpu_wd;
  logic [7:0]    cpu_rd;
  logic          hs_access;
  logic          hs_req;
  logic          hs_write;
  logic [15:0]   hs_address;
  logic [7:0]    hs_data_in;
  logic [7:0]    hs_data_out;
  logic          hs_ack;
  logic [AW-1:0] ram_ad;
  logic          ram_we;
  logic [7:0]    ram_wd;
  logic [7:0]    ram_rd;
  modport slave (
    input  cpu_cs, cpu_wr, cpu_ad, cpu_wd, hs_access, hs_req, hs_write, hs_address, hs_data_in, ram_rd,
    output cpu_rd, hs_data_out, hs_ack, ram_ad, ram_we, ram_wd
  );
  modport master (
    output cpu_cs, cpu_wr, cpu_ad, cpu_wd, hs_access, hs_req, hs_write, hs_address, hs_data_in, ram_rd,
    input  cpu_rd, hs_data_out, hs_ack, ram_ad, ram_we, ram_wd
  );
endinterface

// File: rtl/hs_ram_arb.sv
// hs_ram_arb: shares a single-port work RAM between the CPU (absolute priority) and paused-game hiscore accesses.
module hs_ram_arb import jb_pkg::*; #(
  parameter int         AW     = 11,
  parameter logic [7:0] RD_OOR = RD_OOR_DEF
) (
  input logic        clk48M,
  input logic        reset,
  hs_ram_arb_if.slave bus
);
  state_t        state, state_nx;
  logic [15:0]   lat_addr;
  logic [7:0]    lat_data;
  logic          lat_wr;
  logic          done;
  logic          in_range;
  logic [AW-1:0] ram_ad_q;
  logic [7:0]    ram_wd_q;
  logic [7:0]    cpu_rd_q;
  logic [7:0]    hs_data_q;
  assign in_range = (lat_addr >> AW) == 16'd0;
  // RAM address/data hold their last driven value whenever nobody owns the bus
  assign bus.ram_ad = state == CPU ? bus.cpu_ad :
                      (state == HS_RD || state == HS_WR) && in_range ? lat_addr[AW-1:0] : ram_ad_q;
  assign bus.ram_wd = state == CPU ? bus.cpu_wd : state == HS_WR && in_range ? lat_data : ram_wd_q;
  assign bus.ram_we = state == CPU ? bus.cpu_wr :
                      state == HS_WR && lat_wr && in_range && !bus.cpu_cs && !reset;
  assign bus.hs_ack      = (state == HS_CAP || state == HS_ACK) && !bus.cpu_cs;
  assign bus.cpu_rd      = cpu_rd_q;
  assign bus.hs_data_out = hs_data_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:           state_nx = bus.hs_access && bus.hs_req && !done ? (bus.hs_write ? HS_WR : HS_RD) : IDLE;
      CPU:            state_nx = IDLE;
      HS_RD:          state_nx = HS_CAP;
      HS_WR:          state_nx = HS_ACK;
      HS_CAP, HS_ACK: state_nx = HS_HOLD;
      HS_HOLD:        state_nx = bus.hs_req ? HS_HOLD : IDLE;
      default:        state_nx = IDLE;
    endcase
    if (bus.cpu_cs) state_nx = CPU;
  end
  // done blocks re-service of a request that was acked but is still held, even across a CPU cycle
  always_ff @(posedge clk48M) begin
    if (reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_wr    <= 1'b0;
      done      <= 1'b0;
      ram_ad_q  <= '0;
      ram_wd_q  <= '0;
      cpu_rd_q  <= '0;
      hs_data_q <= '0;
    end else begin
      state    <= state_nx;
      ram_ad_q <= bus.ram_ad;
      ram_wd_q <= bus.ram_wd;
      done     <= bus.hs_ack || (done && bus.hs_req);
      if (state == CPU) cpu_rd_q <= bus.ram_rd;
      if (state == HS_CAP && !bus.cpu_cs) hs_data_q <= in_range ? bus.ram_rd : RD_OOR;
      if (state == IDLE && (state_nx == HS_RD || state_nx == HS_WR)) begin
        lat_addr <= bus.hs_address;
        lat_data <= bus.hs_data_in;
        lat_wr   <= bus.hs_write;
      end
    end
  end
endmodule

// File: tb/tb_hs_ram_arb.sv
// tb_hs_ram_arb: directed plus randomized checks of hs_ram_arb against a byte-array RAM model.
module tb_hs_ram_arb;
  import jb_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] mem [2048];
  logic [7:0] ref_mem [2048];
  logic [7:0] exp_cpu_rd;
  hs_ram_arb_if #(.AW(11)) b ();
  hs_ram_arb #(.AW(11)) dut (.clk48M(clk), .reset(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
    else begin
      if (b.ram_we) mem[b.ram_ad] <= b.ram_wd;
      b.ram_rd <= mem[b.ram_ad];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic hs_op(input logic wr, input logic [15:0] a, input logic [7:0] d, input int hold, input logic drop,
                       output int ack_at, output int acks, output int wes, output logic [10:0] we_ad,
                       output logic [7:0] dout, output logic moved);
    logic [10:0] ad0;
    ack_at = -1; acks = 0; wes = 0; we_ad = '0; dout = 'x; moved = 1'b0; ad0 = '0;
    b.hs_req = 1'b1; b.hs_write = wr; b.hs_address = a; b.hs_data_in = d;
    for (int k = 0; k < 40; k++) begin
      if (drop && k == 1) b.hs_access = 1'b0;
      #1;
      if (k == 0) ad0 = b.ram_ad;
      if (b.ram_ad !== ad0) moved = 1'b1;
      if (b.hs_ack) begin acks++; if (ack_at < 0) ack_at = k; end
      if (b.ram_we) begin wes++; we_ad = b.ram_ad; end
      @(posedge clk); #1;
      if (ack_at >= 0 && k == ack_at) dout = b.hs_data_out;
      if (ack_at >= 0 && k >= ack_at + hold) b.hs_req = 1'b0;
    end
    b.hs_req = 1'b0;
    b.hs_access = 1'b1;
  endtask
  task automatic cpu_op(input logic wr, input logic [10:0] a, input logic [7:0] d);
    b.cpu_cs = 1'b1; b.cpu_wr = wr; b.cpu_ad = a; b.cpu_wd = d;
    repeat (3) @(posedge clk);
    #1;
    b.cpu_cs = 1'b0; b.cpu_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    int at, n, w;
    logic [10:0] wa;
    logic [7:0] dv, d;
    logic mv, wr, oor;
    logic [15:0] a;
    int op;
    rst = 1'b1; ram_clr = 1'b1;
    b.cpu_cs = 0; b.cpu_wr = 0; b.cpu_ad = '0; b.cpu_wd = '0;
    b.hs_access = 0; b.hs_req = 0; b.hs_write = 0; b.hs_address = '0; b.hs_data_in = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    ram_clr = 1'b0;
    chk("rst_state", dut.state, IDLE);
    chk("rst_cpu_rd", b.cpu_rd, 8'h00);
    chk("rst_hs_data_out", b.hs_data_out, 8'h00);
    chk("rst_hs_ack", b.hs_ack, 1'b0);
    chk("rst_ram_we", b.ram_we, 1'b0);
    chk("rst_ram_ad", b.ram_ad, 11'h000);
    chk("rst_ram_wd", b.ram_wd, 8'h00);
    rst = 1'b0; b.hs_access = 1'b1;
    @(posedge clk); #1;
    hs_op(1'b1, 16'h0123, 8'h5A, 0, 1'b0, at, n, w, wa, dv, mv);
    ref_mem[11'h123] = 8'h5A;
    chk("wr_ack_cycle", at, 2);
    chk("wr_ack_count", n, 1);
    chk("wr_we_count", w, 1);
    chk("wr_we_addr", wa, 11'h123);
    chk("wr_ram_data", mem[11'h123], 8'h5A);
    hs_op(1'b0, 16'h0123, 8'h00, 0, 1'b0, at, n, w, wa, dv, mv);
    chk("rd_ack_cycle", at, 2);
    chk("rd_ack_count", n, 1);
    chk("rd_we_count", w, 0);
    chk("rd_data", dv, 8'h5A);
    b.hs_req = 1'b1; b.hs_write = 1'b0; b.hs_address = 16'h0123;
    @(posedge clk); #1;
    chk("pre_state_rd", dut.state, HS_RD);
    b.cpu_cs = 1'b1; b.cpu_ad = 11'h7FF; b.cpu_wr = 1'b0;
    #1;
    chk("pre_ack_in_rd", b.hs_ack, 1'b0);
    @(posedge clk); #1;
    chk("pre_state_cpu", dut.state, CPU);
    chk("pre_ack_in_cpu", b.hs_ack, 1'b0);
    @(posedge clk); #1;
    b.cpu_cs = 1'b0;
    n = 0; dv = 'x;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (b.hs_ack) n++;
      @(posedge clk); #1;
      if (n == 1 && b.hs_req) begin dv = b.hs_data_out; b.hs_req = 1'b0; end
    end
    chk("pre_reservice_acks", n, 1);
    chk("pre_reservice_data", dv, 8'h5A);
    exp_cpu_rd = ref_mem[11'h7FF];
    hs_op(1'b0, 16'h0800, 8'h00, 0, 1'b0, at, n, w, wa, dv, mv);
    chk("oor_ack_cycle", at, 2);
    chk("oor_ack_count", n, 1);
    chk("oor_we_count", w, 0);
    chk("oor_data", dv, 8'hFF);
    chk("oor_ad_moved", mv, 1'b0);
    hs_op(1'b0, 16'h0123, 8'h00, 10, 1'b0, at, n, w, wa, dv, mv);
    chk("hold_ack_count", n, 1);
    b.hs_access = 1'b0; b.hs_req = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (b.hs_ack || dut.state != IDLE) n++;
    end
    chk("noaccess_idle", n, 0);
    b.hs_req = 1'b0; b.hs_access = 1'b1;
    @(posedge clk); #1;
    hs_op(1'b1, 16'h0456, 8'hC3, 0, 1'b1, at, n, w, wa, dv, mv);
    ref_mem[11'h456] = 8'hC3;
    chk("accdrop_ack_cycle", at, 2);
    chk("accdrop_we_count", w, 1);
    chk("accdrop_ram_data", mem[11'h456], 8'hC3);
    chk("cpu_rd_hold", b.cpu_rd, exp_cpu_rd);
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      oor = ($urandom_range(0, 7) == 0);
      a = oor ? 16'($urandom_range(16'h0800, 16'hFFFF)) : 16'($urandom_range(0, 16'h07FF));
      d = 8'($urandom);
      if (op == 3) begin
        wr = 1'($urandom);
        cpu_op(wr, a[10:0], d);
        if (wr) ref_mem[a[10:0]] = d;
        exp_cpu_rd = ref_mem[a[10:0]];
        chk("rnd_cpu_rd", b.cpu_rd, exp_cpu_rd);
      end else begin
        wr = (op < 2);
        hs_op(wr, a, d, int'($urandom_range(0, 3)), 1'b0, at, n, w, wa, dv, mv);
        chk("rnd_ack_cycle", at, 2);
        chk("rnd_ack_count", n, 1);
        chk("rnd_we_count", w, (wr && !oor) ? 1 : 0);
        if (wr && !oor) begin
          ref_mem[a[10:0]] = d;
          chk("rnd_we_addr", wa, a[10:0]);
        end
        if (!wr) chk("rnd_rd_data", dv, oor ? 8'hFF : ref_mem[a[10:0]]);
        chk("rnd_cpu_rd_hold", b.cpu_rd, exp_cpu_rd);
      end
    end
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) chk("ram_image", mem[i], ref_mem[i]);
    b.hs_req = 1'b1; b.hs_write = 1'b1; b.hs_address = 16'h0042; b.hs_data_in = ~ref_mem[11'h042];
    @(posedge clk); #1;
    chk("rstmid_state_wr", dut.state, HS_WR);
    rst = 1'b1;
    #1;
    chk("rstmid_we_during", b.ram_we, 1'b0);
    @(posedge clk); #1;
    chk("rstmid_state", dut.state, IDLE);
    chk("rstmid_ram_we", b.ram_we, 1'b0);
    chk("rstmid_hs_ack", b.hs_ack, 1'b0);
    chk("rstmid_cpu_rd", b.cpu_rd, 8'h00);
    chk("rstmid_hs_data_out", b.hs_data_out, 8'h00);
    chk("rstmid_ram_ad", b.ram_ad, 11'h000);
    chk("rstmid_ram_wd", b.ram_wd, 8'h00);
    chk("rstmid_no_write", mem[11'h042], ref_mem[11'h042]);
    rst = 1'b0; b.hs_req = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hs_ram_arb.md
HS_RAM_ARB -- requirements
Module: hs_ram_arb

Interface
REQ-001 SHALL have parameter AW, default 11, work-RAM address width.
REQ-002 SHALL have parameter RD_OOR, default 8'hFF, read data returned for an out-of-range hiscore address.
REQ-003 SHALL have port clk48M  in  1  system clock; every register is clocked on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_cs  in  1  CPU selects the shared RAM (level, held for the whole bus cycle).
REQ-006 SHALL have ports cpu_wr in 1 (write strobe), cpu_ad in AW (address) and cpu_wd in 8 (write data).
REQ-007 SHALL have port cpu_rd  out  8  registered read data to the CPU.
REQ-008 SHALL have port hs_access  in  1  hiscore mode enable; it is high only while the game is paused.
REQ-009 SHALL have port hs_req  in  1  hiscore request, level; the requester holds it until hs_ack.
REQ-010 SHALL have ports hs_write in 1, hs_address in 16 and hs_data_in in 8, all sampled when the FSM leaves IDLE.
REQ-011 SHALL have ports hs_data_out out 8 (registered read data) and hs_ack out 1 (single-cycle pulse).
REQ-012 SHALL have ports ram_ad out AW, ram_we out 1 and ram_wd out 8 (single-port RAM, one-cycle read latency).
REQ-013 SHALL have port ram_rd  in  8  RAM read data.

Function
REQ-014 SHALL implement these FSM states: IDLE, CPU, HS_RD, HS_CAP, HS_WR, HS_ACK, HS_HOLD.
REQ-015 SHALL give the CPU absolute priority: cpu_cs=1 in any state sends next state to CPU.
REQ-016 When cpu_cs=1 preempts HS_RD, HS_CAP, HS_WR or HS_ACK, the FSM SHALL NOT pulse hs_ack, and the request SHALL be re-serviced from IDLE.
REQ-017 In CPU: ram_ad=cpu_ad, ram_we=cpu_wr, ram_wd=cpu_wd; cpu_rd SHALL load ram_rd every cycle; the FSM SHALL return to IDLE when cpu_cs=0.
REQ-018 cpu_rd SHALL hold its last value outside CPU.
REQ-019 In IDLE with cpu_cs=0, hs_access=1 and hs_req=1: the FSM SHALL latch address, data and write, then go to HS_WR if hs_write=1, else HS_RD.
REQ-020 HS_WR SHALL drive ram_we=1 for exactly one cycle at the latched address and data, then go to HS_ACK.
REQ-021 HS_RD SHALL drive the latched address, then go to HS_CAP.
REQ-022 HS_CAP SHALL load hs_data_out from ram_rd, pulse hs_ack, then go to HS_HOLD.
REQ-023 HS_ACK SHALL pulse hs_ack, then go to HS_HOLD.
REQ-024 Latency from the hs_req-sampled IDLE cycle: hs_ack SHALL be high in the 3rd cycle for both read and write (cycle 0 IDLE, cycle 1 access, cycle 2 ack).
REQ-025 HS_HOLD SHALL wait for hs_req=0 and then go to IDLE, so a held request is never serviced twice.
REQ-026 A latched address with any bit at or above AW set SHALL be out of range: no RAM access, ram_we stays 0, the read returns RD_OOR, and hs_ack keeps the same timing.
REQ-027 hs_access=0 SHALL block entry to any HS state.
REQ-028 If hs_access falls mid-operation, the FSM SHALL complete the operation and ack it.
REQ-029 ram_we SHALL be 0 in IDLE, HS_RD, HS_CAP, HS_ACK and HS_HOLD.

Reset
REQ-030 On reset the FSM SHALL be in IDLE, with cpu_rd=0, hs_data_out=0, hs_ack=0, ram_we=0, ram_ad=0, ram_wd=0 and all latches cleared.
REQ-031 A reset asserted mid-operation SHALL abort it, with no ack and no write.

Structure
REQ-032 The FSM state encoding and the RD_OOR default SHALL live in shared package jb_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the RAM is external.

Verification
REQ-034 Bench SHALL cover: hs write while cpu_cs=0, hs_access=1, hs_address=16'h0123, hs_data_in=8'h5A -> ram_we=1 for one cycle at ram_ad=11'h123, hs_ack in cycle 2.
REQ-035 Bench SHALL cover: hs read of 16'h0123 after that write -> hs_data_out=8'h5A, hs_ack in cycle 2, ram_we=0 throughout.
REQ-036 Bench SHALL cover: cpu_cs rises in the HS_RD cycle -> FSM goes to CPU, no ack; after cpu_cs falls, the read is re-serviced and acked exactly once.
REQ-037 Bench SHALL cover: hs read of 16'h0800 with AW=11 -> hs_data_out=8'hFF, hs_ack, no write, ram_ad unchanged by the request.
REQ-038 Bench SHALL cover: hs_req held high for 10 cycles after ack -> exactly one hs_ack pulse; with hs_access=0, hs_req=1 -> FSM stays in IDLE.
REQ-039 Bench SHALL cover: reset asserted during HS_WR -> next cycle IDLE, ram_we=0, hs_ack=0, and all outputs at their reset values.
